mac_array_sched: RTL

//   Sequencer and round-robin arbiter that shares one mac_array between NUM_REQ requesters.

---
 rtl/mac_sched_pkg.sv | 16 +
 rtl/mac_sched_if.sv | 30 +++
 rtl/mac_sched_rr_arb.sv | 27 ++
 rtl/mac_array_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types for the mac_array scheduler: FSM state encoding and perf counter widths.
package mac_sched_pkg;

  localparam int STATE_W     = 3;
  localparam int PERF_BUSY_W = 32;
  localparam int PERF_JOBS_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } sched_state_e;

endpackage

// File: rtl/mac_sched_if.sv
// Requester/consumer side bus of the mac_array scheduler: job requests, array controls, result handshake.
interface mac_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     mac_clr;
  logic                     mac_en;
  logic [IDX_W-1:0]         op_sel;
  logic [LEN_W-1:0]         op_idx;
  logic                     res_valid;
  logic                     res_ready;
  logic [IDX_W-1:0]         res_owner;
  logic                     busy;

  modport master (
    output req_valid, req_len, res_ready,
    input  req_ready, mac_clr, mac_en, op_sel, op_idx, res_valid, res_owner, busy
  );

  modport slave (
    input  req_valid, req_len, res_ready,
    output req_ready, mac_clr, mac_en, op_sel, op_idx, res_valid, res_owner, busy
  );

endinterface

// File: rtl/mac_sched_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping mod NUM_REQ.
module mac_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_vld,
  output logic [IDX_W-1:0]   grant_id
);

  always_comb begin
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && req_valid[IDX_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_id  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mac_array_sched.sv
// Sequencer + round-robin arbiter sharing one mac_array among NUM_REQ requesters.
// Optional perf counters (perf_busy_cyc, perf_jobs) are built when MAC_SCHED_PERF_EN is defined.
module mac_array_sched
  import mac_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst,
  mac_sched_if.slave bus
`ifdef MAC_SCHED_PERF_EN
  ,
  output logic [PERF_BUSY_W-1:0] perf_busy_cyc,
  output logic [PERF_JOBS_W-1:0] perf_jobs
`endif
);

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  sched_state_e       state, state_n;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   op_idx_q;
  logic [DRAIN_W-1:0] drain_cnt;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_id;
  logic [LEN_W-1:0]   grant_len;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               accept;

  logic mac_clr_q, mac_en_q, res_valid_q, busy_q;

  mac_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // Next-state and accept decode. req_ready is the only output formed from the
  // current inputs, so a job can be accepted in the first IDLE cycle.
  always_comb begin
    state_n     = state;
    req_ready_c = '0;
    accept      = 1'b0;
    grant_len   = bus.req_len[grant_id*LEN_W +: LEN_W];
    case (state)
      IDLE: begin
        if (grant_vld && !rst) begin
          req_ready_c[grant_id] = 1'b1;
          accept                = 1'b1;
          if (grant_len != '0) state_n = CLEAR;
        end
      end
      CLEAR:   state_n = RUN;
      RUN:     if (op_idx_q == len_q - LEN_W'(1)) state_n = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_n = RESULT;
      RESULT:  if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, job context and registered array/result outputs, all decoded from
  // the next state so each output lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      len_q       <= '0;
      op_idx_q    <= '0;
      drain_cnt   <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        owner  <= grant_id;
        len_q  <= grant_len;
        rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (state == RUN && state_n == RUN) op_idx_q <= op_idx_q + 1'b1;
      else                                op_idx_q <= '0;
      if (state != DRAIN && state_n == DRAIN)   drain_cnt <= DRAIN_W'(MAC_LAT - 1);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      mac_clr_q   <= (state_n == CLEAR);
      mac_en_q    <= (state_n == RUN);
      res_valid_q <= (state_n == RESULT);
      busy_q      <= (state_n != IDLE);
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.op_sel    = owner;
  assign bus.op_idx    = op_idx_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_owner = owner;
  assign bus.busy      = busy_q;

`ifdef MAC_SCHED_PERF_EN
  // Saturating activity counters; zero-length accepts are not counted as jobs.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cyc <= '0;
      perf_jobs     <= '0;
    end else begin
      if (busy_q && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 1'b1;
      if (accept && grant_len != '0 && perf_jobs != '1) perf_jobs <= perf_jobs + 1'b1;
    end
  end
`endif

endmodule
